// File: rtl/debouncer_multi.sv
// N-channel pushbutton debouncer: 2-flop sync, shared sample tick, per-channel stability count.
// Define DEBOUNCER_MULTI_AUTO_REPEAT_EN to add auto-repeat press pulses on held buttons.
module debouncer_multi #(
    parameter int unsigned N_CH         = 4,
    parameter int unsigned SAMPLE_DIV   = 250000,
    parameter int unsigned STABLE_CNT   = 4,
    parameter int unsigned HOLD_TICKS   = 200,
    parameter int unsigned REPEAT_TICKS = 40
) (
    input  logic            in_clk,
    input  logic            rst,
    input  logic [N_CH-1:0] pushbutton,
    output logic [N_CH-1:0] level,
    output logic [N_CH-1:0] press,
    // "release" is a reserved word, hence the suffix
    output logic [N_CH-1:0] release_pulse,
    output logic            tick
);

    localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(STABLE_CNT + 1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CNT - 1);

    if (N_CH < 1 || SAMPLE_DIV < 1 || STABLE_CNT < 1 || REPEAT_TICKS < 1 ||
        HOLD_TICKS < REPEAT_TICKS) begin : g_param_check
        $error("debouncer_multi: illegal parameter combination");
    end

    logic [N_CH-1:0] sync1;
    logic [N_CH-1:0] sync2;

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= pushbutton;
            sync2 <= sync1;
        end
    end

    logic [DIV_W-1:0] div_cnt;
    logic             tick_raw;

    assign tick_raw = (div_cnt == DIV_LAST);
    // Gated so the strobe reads 0 during reset even when SAMPLE_DIV=1.
    assign tick     = tick_raw & ~rst;

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
        end else if (tick_raw) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    logic [N_CH-1:0][CNT_W-1:0] cnt_q;
    logic [N_CH-1:0][CNT_W-1:0] cnt_d;
    logic [N_CH-1:0]            differ;
    logic [N_CH-1:0]            accept;
    logic [N_CH-1:0]            level_d;
    logic [N_CH-1:0]            press_d;
    logic [N_CH-1:0]            release_d;
    logic [N_CH-1:0]            repeat_fire;

    assign differ = sync2 ^ level;

    always_comb begin
        cnt_d     = cnt_q;
        accept    = '0;
        level_d   = level;
        press_d   = '0;
        release_d = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (tick_raw) begin
                if (differ[i]) begin
                    if (cnt_q[i] == CNT_LAST) begin
                        accept[i]  = 1'b1;
                        cnt_d[i]   = '0;
                        level_d[i] = sync2[i];
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end else begin
                    cnt_d[i] = '0;
                end
            end
            press_d[i]   = accept[i] & sync2[i];
            release_d[i] = accept[i] & ~sync2[i];
        end
    end

`ifdef DEBOUNCER_MULTI_AUTO_REPEAT_EN
    localparam int unsigned HOLD_W_H = $clog2(HOLD_TICKS + 1);
    localparam int unsigned HOLD_W_R = $clog2(REPEAT_TICKS + 1);
    localparam int unsigned HOLD_W   = (HOLD_W_H > HOLD_W_R) ? HOLD_W_H : HOLD_W_R;
    localparam logic [HOLD_W-1:0] HOLD_LAST   = HOLD_W'(HOLD_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_RELOAD = HOLD_W'(HOLD_TICKS - REPEAT_TICKS);

    logic [N_CH-1:0][HOLD_W-1:0] hold_q;
    logic [N_CH-1:0][HOLD_W-1:0] hold_d;

    // Fire on the tick that would bring the count to HOLD_TICKS, then reload so the
    // next pulse lands REPEAT_TICKS ticks later. Any level change clears the count.
    always_comb begin
        hold_d      = hold_q;
        repeat_fire = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (accept[i] || !level[i]) begin
                hold_d[i] = '0;
            end else if (tick_raw) begin
                if (hold_q[i] == HOLD_LAST) begin
                    repeat_fire[i] = 1'b1;
                    hold_d[i]      = HOLD_RELOAD;
                end else begin
                    hold_d[i] = hold_q[i] + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end
`else
    assign repeat_fire = '0;
`endif

    always_ff @(posedge in_clk or posedge rst) begin
        if (rst) begin
            cnt_q         <= '0;
            level         <= '0;
            press         <= '0;
            release_pulse <= '0;
        end else begin
            cnt_q         <= cnt_d;
            level         <= level_d;
            press         <= press_d | repeat_fire;
            release_pulse <= release_d;
        end
    end

endmodule

// File: tb/tb_debouncer_multi.sv
// Self-checking bench for debouncer_multi: two instances (SAMPLE_DIV=1/3 and 4/2) against
// a sample-window reference model, with directed scenarios and randomized button activity.
module tb_debouncer_multi;

    localparam int NCH    = 4;
    localparam int H      = 10;
    localparam int R      = 3;
    localparam int DIV_A  = 1;
    localparam int STAB_A = 3;
    localparam int DIV_B  = 4;
    localparam int STAB_B = 2;
`ifdef DEBOUNCER_MULTI_AUTO_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic           in_clk = 1'b0;
    logic           rst    = 1'b1;
    logic [NCH-1:0] pb_a   = '0;
    logic [NCH-1:0] pb_b   = '0;
    logic [NCH-1:0] level_a, press_a, rel_a;
    logic [NCH-1:0] level_b, press_b, rel_b;
    logic           tick_a, tick_b;

    int checks   = 0;
    int failures = 0;

    debouncer_multi #(
        .N_CH(NCH), .SAMPLE_DIV(DIV_A), .STABLE_CNT(STAB_A), .HOLD_TICKS(H), .REPEAT_TICKS(R)
    ) dut_a (
        .in_clk(in_clk), .rst(rst), .pushbutton(pb_a), .level(level_a), .press(press_a),
        .release_pulse(rel_a), .tick(tick_a)
    );

    debouncer_multi #(
        .N_CH(NCH), .SAMPLE_DIV(DIV_B), .STABLE_CNT(STAB_B), .HOLD_TICKS(H), .REPEAT_TICKS(R)
    ) dut_b (
        .in_clk(in_clk), .rst(rst), .pushbutton(pb_b), .level(level_b), .press(press_b),
        .release_pulse(rel_b), .tick(tick_b)
    );

    always #5 in_clk = ~in_clk;

    // Reference model: sampled input = raw input two edges late; a channel flips once
    // the last STABLE_CNT samples all disagree with its current level.
    int             div_m[2];
    int             stab_m[2];
    int             edges[2];
    logic [NCH-1:0] d1[2];
    logic [NCH-1:0] d2[2];
    logic [NCH-1:0] hist[2][8];
    logic [NCH-1:0] e_lvl[2];
    logic [NCH-1:0] e_press[2];
    logic [NCH-1:0] e_rel[2];
    int             held[2][NCH];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            edges[d]   = 0;
            d1[d]      = '0;
            d2[d]      = '0;
            e_lvl[d]   = '0;
            e_press[d] = '0;
            e_rel[d]   = '0;
            for (int k = 0; k < 8; k++) hist[d][k] = '0;
            for (int c = 0; c < NCH; c++) held[d][c] = 0;
        end
    endtask

    task automatic model_edge(input int d, input logic [NCH-1:0] pbv);
        bit acc;
        e_press[d] = '0;
        e_rel[d]   = '0;
        if (((edges[d] + 1) % div_m[d]) == 0) begin
            for (int k = 7; k >= 1; k--) hist[d][k] = hist[d][k-1];
            hist[d][0] = d2[d];
            for (int c = 0; c < NCH; c++) begin
                acc = 1'b1;
                for (int k = 0; k < stab_m[d]; k++) begin
                    if (hist[d][k][c] == e_lvl[d][c]) acc = 1'b0;
                end
                if (acc) begin
                    e_lvl[d][c] = ~e_lvl[d][c];
                    if (e_lvl[d][c]) begin
                        e_press[d][c] = 1'b1;
                        held[d][c]    = 0;
                    end else begin
                        e_rel[d][c] = 1'b1;
                    end
                end else if (REP_EN && e_lvl[d][c]) begin
                    held[d][c]++;
                    if (held[d][c] == H || (held[d][c] > H && ((held[d][c] - H) % R) == 0))
                        e_press[d][c] = 1'b1;
                end
            end
        end
        d2[d] = d1[d];
        d1[d] = pbv;
        edges[d]++;
    endtask

    task automatic check_all();
        chk("level_a", level_a, e_lvl[0]);
        chk("press_a", press_a, e_press[0]);
        chk("release_a", rel_a, e_rel[0]);
        chk("tick_a", tick_a, ((edges[0] + 1) % DIV_A) == 0);
        chk("level_b", level_b, e_lvl[1]);
        chk("press_b", press_b, e_press[1]);
        chk("release_b", rel_b, e_rel[1]);
        chk("tick_b", tick_b, ((edges[1] + 1) % DIV_B) == 0);
    endtask

    task automatic step();
        @(posedge in_clk);
        model_edge(0, pb_a);
        model_edge(1, pb_b);
        #1;
        check_all();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int n_press;
    int n_rel;
    bit seen_rel;

    initial begin
        div_m[0]  = DIV_A;
        div_m[1]  = DIV_B;
        stab_m[0] = STAB_A;
        stab_m[1] = STAB_B;
        model_reset();

        // Reset state
        #12;
        chk("rst_level_a", level_a, 0);
        chk("rst_press_a", press_a, 0);
        chk("rst_rel_a", rel_a, 0);
        chk("rst_tick_a", tick_a, 0);
        chk("rst_tick_b", tick_b, 0);
        @(posedge in_clk);
        #1 rst = 1'b0;

        // Clean press: accepted on the fifth edge
        pb_a[0] = 1'b1;
        run(4);
        chk("clean_wait", level_a[0], 0);
        step();
        chk("clean_level", level_a[0], 1);
        chk("clean_press", press_a[0], 1);
        step();
        chk("clean_press_end", press_a[0], 0);
        chk("clean_hold", level_a[0], 1);

        // Bounce rejection: two samples short of three
        pb_a[1] = 1'b1;
        run(2);
        pb_a[1] = 1'b0;
        run(8);
        chk("bounce_level", level_a[1], 0);

        // Simultaneous release of channels 0 and 2
        pb_a[2] = 1'b1;
        run(6);
        pb_a[0] = 1'b0;
        pb_a[2] = 1'b0;
        run(4);
        step();
        chk("rel_both", rel_a, 4'b0101);
        chk("rel_levels", level_a, 4'b0000);

        // Divider instance: stable press, then a short glitch
        pb_b[0] = 1'b1;
        run(14);
        chk("div_press_level", level_b[0], 1);
        pb_b[1] = 1'b1;
        run(2);
        pb_b[1] = 1'b0;
        run(12);
        chk("div_glitch_level", level_b[1], 0);

        // Randomized button activity
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 5) == 0) pb_a[$urandom_range(0, NCH - 1)] ^= 1'b1;
            if ($urandom_range(0, 3) == 0) pb_b[$urandom_range(0, NCH - 1)] ^= 1'b1;
            step();
        end

        // Reset mid-debounce with channel 0 held and channel 3 counting
        pb_a = 4'b0001;
        pb_b = '0;
        run(12);
        chk("pre_rst_level", level_a, 4'b0001);
        pb_a[3] = 1'b1;
        run(4);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_level_a", level_a, 0);
        chk("mid_rst_press_a", press_a, 0);
        chk("mid_rst_tick_a", tick_a, 0);
        chk("mid_rst_level_b", level_b, 0);
        model_reset();
        @(posedge in_clk);
        #1 rst = 1'b0;
        run(4);
        chk("post_rst_wait", level_a[3], 0);
        step();
        chk("post_rst_press", press_a, 4'b1001);

        // Held button: auto-repeat pulses only when the feature is built in
        n_press = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (press_a[3]) n_press++;
        end
        chk("repeat_count", n_press, REP_EN ? 7 : 0);

        pb_a[3]  = 1'b0;
        n_press  = 0;
        n_rel    = 0;
        seen_rel = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (seen_rel && press_a[3]) n_press++;
            if (rel_a[3]) begin
                n_rel++;
                seen_rel = 1'b1;
            end
        end
        chk("release_count", n_rel, 1);
        chk("press_after_release", n_press, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
